wbs_sram_ctrl: RTL and testbench

//  Wishbone slave: responder end of the hehe core / wb_interconnect master path.

---
 rtl/wbs_sram_pkg.sv | 9 +
 rtl/wbs_burst_addr_gen.sv | 36 +++
 rtl/wbs_sram_ctrl.sv | 105 ++++++++++
 tb/tb_wbs_sram_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wbs_sram_pkg.sv
// wbs_sram_pkg: shared types and helpers for the Wishbone SRAM slave.
package wbs_sram_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, ACC, RESP, ERR} state_t;
    localparam int WAIT_CNT_W = 4;
    localparam int ADR_MAX_W = 64;
    function automatic logic [ADR_MAX_W-1:0] word_addr(input logic [ADR_MAX_W-1:0] adr);
        return adr >> 2;
    endfunction
endpackage

// File: rtl/wbs_burst_addr_gen.sv
// wbs_burst_addr_gen: burst word-address and beat tracking with end-of-memory lookahead.
module wbs_burst_addr_gen #(
    parameter int MEM_WORDS = 16384,
    parameter int MEM_AW = 14,
    parameter int BL_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [MEM_AW-1:0] base,
    input  logic [BL_W-1:0]   bl,
    output logic [MEM_AW-1:0] addr,
    output logic              last,
    output logic              next_oor
);
    logic [BL_W-1:0] beat;
    logic [BL_W-1:0] bl_q;
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            beat <= '0;
            bl_q <= '0;
        end else if (load) begin
            addr <= base;
            beat <= '0;
            bl_q <= (bl == '0) ? BL_W'(1) : bl;
        end else if (adv) begin
            addr <= addr + 1'b1;
            beat <= beat + 1'b1;
        end
    end
    assign last = beat == bl_q - BL_W'(1);
    // One extra bit so the step past the top word is visible even for power-of-two depths
    assign next_oor = ({1'b0, addr} + 1'b1) >= (MEM_AW + 1)'(MEM_WORDS);
endmodule

// File: rtl/wbs_sram_ctrl.sv
// wbs_sram_ctrl: Wishbone slave fronting a 1-cycle-latency synchronous SRAM,
// with incrementing bursts, byte-lane writes, wait states and address errors.
module wbs_sram_ctrl
    import wbs_sram_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int MEM_WORDS = 16384,
    parameter int WAIT_STATES = 0,
    parameter int BL_W = 10,
    localparam int SEL_W = DW / 8,
    localparam int MEM_AW = $clog2(MEM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              s_wbd_cyc_i,
    input  logic              s_wbd_stb_i,
    input  logic              s_wbd_we_i,
    input  logic [AW-1:0]     s_wbd_adr_i,
    input  logic [SEL_W-1:0]  s_wbd_sel_i,
    input  logic [DW-1:0]     s_wbd_dat_i,
    input  logic [BL_W-1:0]   s_wbd_bl_i,
    input  logic              s_wbd_bry_i,
    output logic [DW-1:0]     s_wbd_dat_o,
    output logic              s_wbd_ack_o,
    output logic              s_wbd_lack_o,
    output logic              s_wbd_err_o,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic [SEL_W-1:0]  mem_wmask_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);
    state_t state, state_nx, beat_start;
    logic [WAIT_CNT_W-1:0] wcnt;
    logic we_q, held, accept, in_range, ack, acc, beat_go, last, next_oor;
    logic [SEL_W-1:0] sel_q;
    logic [ADR_MAX_W-1:0] wa;
    logic [MEM_AW-1:0] addr;

    assign wa = word_addr(ADR_MAX_W'(s_wbd_adr_i));
    assign in_range = wa < ADR_MAX_W'(MEM_WORDS);
    assign accept = state == IDLE && s_wbd_cyc_i && s_wbd_stb_i;
    assign beat_start = (WAIT_STATES > 0) ? WAIT : ACC;
    // held marks the stall cycles after a beat's ack while the master is not ready
    assign ack = state == RESP && !held && s_wbd_cyc_i;
    assign beat_go = state == RESP && s_wbd_cyc_i && !last && s_wbd_bry_i;

    wbs_burst_addr_gen #(.MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW), .BL_W(BL_W)) u_addr (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .load(accept),
        .adv(beat_go),
        .base(wa[MEM_AW-1:0]),
        .bl(s_wbd_bl_i),
        .addr(addr),
        .last(last),
        .next_oor(next_oor)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = in_range ? beat_start : ERR;
            WAIT: if (wcnt == WAIT_CNT_W'(WAIT_STATES - 1)) state_nx = ACC;
            ACC:  state_nx = RESP;
            RESP: if (ack && last) state_nx = IDLE;
                  else if (s_wbd_bry_i) state_nx = next_oor ? ERR : beat_start;
            ERR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && !s_wbd_cyc_i) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt <= '0;
            held <= 1'b0;
            we_q <= 1'b0;
            sel_q <= '0;
        end else begin
            state <= state_nx;
            wcnt <= (state == WAIT && state_nx == WAIT) ? wcnt + 1'b1 : '0;
            held <= state == RESP && state_nx == RESP;
            if (accept) begin
                we_q <= s_wbd_we_i;
                sel_q <= s_wbd_sel_i;
            end
        end
    end

    // A write with no enabled lanes completes on the bus without touching the SRAM
    assign acc = state == ACC && s_wbd_cyc_i;
    assign mem_cs_o = acc && (!we_q || |sel_q);
    assign mem_we_o = mem_cs_o && we_q;
    assign mem_wmask_o = mem_we_o ? sel_q : '0;
    assign mem_wdata_o = mem_we_o ? s_wbd_dat_i : '0;
    assign mem_addr_o = mem_cs_o ? addr : '0;
    assign s_wbd_ack_o = ack;
    assign s_wbd_lack_o = ack && last;
    assign s_wbd_err_o = state == ERR && s_wbd_cyc_i;
    assign s_wbd_dat_o = (ack && !we_q) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_wbs_sram_ctrl.sv
// tb_wbs_sram_ctrl: directed checks of the Wishbone SRAM slave (no-wait and 3-wait instances).
module tb_wbs_sram_ctrl;
    import wbs_sram_pkg::*;
    logic clk_i = 1'b0, rst_n = 1'b0;
    logic cyc0 = 1'b0, cyc3 = 1'b0, stb = 1'b0, we = 1'b0, bry = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0] sel = '0;
    logic [9:0] bl = '0;
    logic [31:0] dat0, wdata0, rdata0, dat3, wdata3, rdata3;
    logic ack0, lack0, err0, cs0, we0, ack3, lack3, err3, cs3, we3;
    logic [3:0] wmask0, wmask3;
    logic [7:0] addr0, addr3;
    logic [31:0] mem0 [256];
    logic pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int checks = 0, failures = 0, cs_cnt0 = 0, cs_cnt3 = 0;
    logic [7:0] last_addr0;
    logic [3:0] last_mask0;
    logic last_we0;
    bit use3 = 1'b0;
    logic ack_x, lack_x, err_x;
    logic [31:0] dat_x;
    logic [15:0] ack_m, lack_m, err_m;
    logic [31:0] rd_q [$];
    int c0, c3;

    always #5 clk_i = ~clk_i;

    wbs_sram_ctrl #(.DW(32), .AW(32), .MEM_WORDS(256), .WAIT_STATES(0), .BL_W(10)) u0 (
        .clk_i(clk_i), .rst_n(rst_n), .s_wbd_cyc_i(cyc0), .s_wbd_stb_i(stb), .s_wbd_we_i(we),
        .s_wbd_adr_i(adr), .s_wbd_sel_i(sel), .s_wbd_dat_i(dat), .s_wbd_bl_i(bl), .s_wbd_bry_i(bry),
        .s_wbd_dat_o(dat0), .s_wbd_ack_o(ack0), .s_wbd_lack_o(lack0), .s_wbd_err_o(err0),
        .mem_cs_o(cs0), .mem_we_o(we0), .mem_wmask_o(wmask0), .mem_addr_o(addr0),
        .mem_wdata_o(wdata0), .mem_rdata_i(rdata0));

    wbs_sram_ctrl #(.DW(32), .AW(32), .MEM_WORDS(256), .WAIT_STATES(3), .BL_W(10)) u3 (
        .clk_i(clk_i), .rst_n(rst_n), .s_wbd_cyc_i(cyc3), .s_wbd_stb_i(stb), .s_wbd_we_i(we),
        .s_wbd_adr_i(adr), .s_wbd_sel_i(sel), .s_wbd_dat_i(dat), .s_wbd_bl_i(bl), .s_wbd_bry_i(bry),
        .s_wbd_dat_o(dat3), .s_wbd_ack_o(ack3), .s_wbd_lack_o(lack3), .s_wbd_err_o(err3),
        .mem_cs_o(cs3), .mem_we_o(we3), .mem_wmask_o(wmask3), .mem_addr_o(addr3),
        .mem_wdata_o(wdata3), .mem_rdata_i(rdata3));

    // Byte-masked SRAM model behind u0, with a bench-side preload port
    always @(posedge clk_i) begin
        if (pre_we) mem0[pre_addr] <= pre_data;
        else if (cs0) begin
            if (we0) begin
                for (int b = 0; b < 4; b++) if (wmask0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
            end else rdata0 <= mem0[addr0];
        end
    end

    // u3 only reads: its SRAM returns a word-address signature
    always @(posedge clk_i) if (cs3 && !we3) rdata3 <= 32'hC0DE_0000 | {24'h0, addr3};

    always @(negedge clk_i) begin
        if (cs0) begin
            cs_cnt0 <= cs_cnt0 + 1;
            last_addr0 <= addr0;
            last_mask0 <= wmask0;
            last_we0 <= we0;
        end
        if (cs3) cs_cnt3 <= cs_cnt3 + 1;
    end

    assign ack_x = use3 ? ack3 : ack0;
    assign lack_x = use3 ? lack3 : lack0;
    assign err_x = use3 ? err3 : err0;
    assign dat_x = use3 ? dat3 : dat0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk_i); #1;
        pre_we = 1'b0;
    endtask

    // One transaction over a fixed 16-cycle window; cycle 0 is the acceptance cycle
    task automatic run(input bit inst, input bit we_v, input logic [31:0] adr_v, input logic [3:0] sel_v,
                       input logic [31:0] dat_v, input logic [9:0] bl_v, input logic [15:0] stall, input bit drop1);
        bit stop = 1'b0;
        ack_m = '0; lack_m = '0; err_m = '0; rd_q.delete();
        use3 = inst;
        @(posedge clk_i); #1;
        cyc0 = !inst; cyc3 = inst; stb = 1'b1; we = we_v; adr = adr_v; sel = sel_v; dat = dat_v; bl = bl_v;
        bry = !stall[0];
        for (int n = 0; n < 16; n++) begin
            @(negedge clk_i);
            if (ack_x) begin ack_m[n] = 1'b1; rd_q.push_back(dat_x); if (drop1) stop = 1'b1; end
            if (lack_x) begin lack_m[n] = 1'b1; stop = 1'b1; end
            if (err_x) begin err_m[n] = 1'b1; stop = 1'b1; end
            @(posedge clk_i); #1;
            bry = (n < 15) ? !stall[n+1] : 1'b1;
            if (stop) begin cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; end
        end
    endtask

    initial begin
        #12;
        chk("rst_ctl", {28'h0, ack0, lack0, err0, cs0}, 32'h0);
        chk("rst_mem", {23'h0, we0, wmask0, addr0 == 8'h0}, 32'h1);
        chk("rst_dat", dat0, 32'h0);
        @(posedge clk_i); #1;
        rst_n = 1'b1;

        run(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 10'd1, 16'h0, 0);
        chk("t1_wr_ack", {16'h0, ack_m}, 32'h0004);
        chk("t1_wr_lack", {16'h0, lack_m}, 32'h0004);
        chk("t1_wr_addr", {24'h0, last_addr0}, 32'h4);
        chk("t1_wr_mask", {27'h0, last_we0, last_mask0}, 32'h1F);
        chk("t1_mem", mem0[4], 32'hDEADBEEF);
        run(0, 0, 32'h10, 4'hF, 32'h0, 10'd1, 16'h0, 0);
        chk("t1_rd_ack", {16'h0, ack_m}, 32'h0004);
        chk("t1_rd_dat", rd_q[0], 32'hDEADBEEF);

        run(0, 1, 32'h10, 4'b0010, 32'h0000AB00, 10'd0, 16'h0, 0);
        chk("t2_mask", {28'h0, last_mask0}, 32'h2);
        chk("t2_bl0_lack", {16'h0, lack_m}, 32'h0004);
        run(0, 0, 32'h10, 4'hF, 32'h0, 10'd1, 16'h0, 0);
        chk("t2_rd_dat", rd_q[0], 32'hDEADABEF);

        for (int k = 0; k < 4; k++) poke(8'(8'h40 + k), 32'hA5A5_0040 + k);
        c0 = cs_cnt0;
        run(0, 0, 32'h100, 4'hF, 32'h0, 10'd4, 16'h001C, 0);
        chk("t3_ack", {16'h0, ack_m}, 32'h0A84);
        chk("t3_lack", {16'h0, lack_m}, 32'h0800);
        chk("t3_cs", 32'(cs_cnt0 - c0), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("t3_dat%0d", k), rd_q[k], 32'hA5A5_0040 + k);

        c0 = cs_cnt0;
        run(0, 0, 32'd1024, 4'hF, 32'h0, 10'd1, 16'h0, 0);
        chk("t4_err", {16'h0, err_m}, 32'h0002);
        chk("t4_ack", {16'h0, ack_m}, 32'h0);
        chk("t4_cs", 32'(cs_cnt0 - c0), 32'd0);

        c0 = cs_cnt0;
        run(0, 0, 32'h3F8, 4'hF, 32'h0, 10'd4, 16'h0, 0);
        chk("t7_ack", {16'h0, ack_m}, 32'h0014);
        chk("t7_err", {16'h0, err_m}, 32'h0020);
        chk("t7_lack", {16'h0, lack_m}, 32'h0);
        chk("t7_cs", 32'(cs_cnt0 - c0), 32'd2);

        c3 = cs_cnt3;
        run(1, 0, 32'h40, 4'hF, 32'h0, 10'd2, 16'h0, 1);
        chk("t5_ack", {16'h0, ack_m}, 32'h0020);
        chk("t5_dat", rd_q[0], 32'hC0DE0010);
        chk("t5_lack_err", {lack_m, err_m}, 32'h0);
        chk("t5_cs", 32'(cs_cnt3 - c3), 32'd1);
        chk("t5_idle", 32'(u3.state), 32'(IDLE));

        poke(8'h08, 32'h11111111);
        use3 = 1'b0;
        @(posedge clk_i); #1;
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat = 32'h22222222; bl = 10'd1; bry = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_acc", {31'h0, cs0 & we0}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_ctl", {26'h0, cs0, we0, ack0, lack0, err0, wmask0 != 4'h0}, 32'h0);
        chk("t6_bus", {wdata0 | {24'h0, addr0}}, 32'h0);
        cyc0 = 1'b0; stb = 1'b0;
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_dropped", mem0[8], 32'h11111111);
        run(0, 1, 32'h20, 4'hF, 32'h22222222, 10'd1, 16'h0, 0);
        chk("t6_after_ack", {16'h0, ack_m}, 32'h0004);
        chk("t6_after_mem", mem0[8], 32'h22222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
